// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types and constants for the RV64 instruction fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int          PC_W      = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3,
    HOLD = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } fetch_pkt_t;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ============================================================================
// fetch_skid_buf : one-entry holding register for a fetched {instr, pc} packet
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc_in,
  output logic            full,
  output logic [31:0]     instr_out,
  output logic [PC_W-1:0] pc_out
);

  fetch_pkt_t r_pkt;
  logic       r_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_pkt  <= '{instr: NOP_INSTR, pc: '0};
    end else begin
      // Emptying wins over a same-cycle load so a flush can never be missed.
      if (clear || unload) begin
        r_full <= 1'b0;
      end else if (load) begin
        r_full <= 1'b1;
      end
      if (load) begin
        r_pkt <= '{instr: instr_in, pc: pc_in};
      end
    end
  end

  assign full      = r_full;
  assign instr_out = r_pkt.instr;
  assign pc_out    = r_pkt.pc;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : RV64 PC owner, single-outstanding imem fetch, IF/ID register
// Rev 1.0 -- optional perf counters under `define FETCH_PERF_EN
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            stall,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [PC_W-1:0] id_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);

  fetch_state_e    r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic            w_hs, w_capture, w_drop;
  logic            w_id_load;
  logic [31:0]     w_id_instr_nxt;
  logic [PC_W-1:0] w_id_pc_nxt;
  logic            w_skid_load, w_skid_unload, w_skid_clear;
  logic            w_skid_full;
  logic [31:0]     w_skid_instr;
  logic [PC_W-1:0] w_skid_pc;

  assign imem_req_valid = (r_state == REQ);
  assign imem_req_addr  = r_pc;
  assign w_hs           = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_capture      = 1'b0;
    w_drop         = 1'b0;
    w_id_load      = 1'b0;
    w_id_instr_nxt = imem_rsp_data;
    w_id_pc_nxt    = r_pc;
    w_skid_load    = 1'b0;
    w_skid_unload  = 1'b0;
    w_skid_clear   = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = w_hs ? DROP : REQ;
        end else if (w_hs) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid && !redirect_valid) begin
          w_capture = 1'b1;
          w_pc_nxt  = r_pc + 64'd4;
          if (!id_valid || !stall) begin
            w_id_load   = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_skid_load = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_drop      = imem_rsp_valid;
          w_state_nxt = imem_rsp_valid ? REQ : DROP;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
        end
        // The stale response retires the outstanding request; pc already holds the target.
        if (imem_rsp_valid) begin
          w_drop      = 1'b1;
          w_state_nxt = REQ;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_skid_clear = 1'b1;
          w_pc_nxt     = redirect_pc;
          w_state_nxt  = REQ;
        end else if (!stall) begin
          w_skid_unload  = 1'b1;
          w_id_load      = w_skid_full;
          w_id_instr_nxt = w_skid_instr;
          w_id_pc_nxt    = w_skid_pc;
          w_state_nxt    = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_skid_load),
    .unload    (w_skid_unload),
    .clear     (w_skid_clear),
    .instr_in  (imem_rsp_data),
    .pc_in     (r_pc),
    .full      (w_skid_full),
    .instr_out (w_skid_instr),
    .pc_out    (w_skid_pc)
  );

  // A redirect flush takes priority over both stall and a same-cycle capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
    end else if (redirect_valid) begin
      id_valid <= 1'b0;
    end else if (w_id_load) begin
      id_valid <= 1'b1;
      id_instr <= w_id_instr_nxt;
      id_pc    <= w_id_pc_nxt;
    end else if (!stall) begin
      id_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (w_capture) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (w_drop)    perf_drop_cnt  <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RV64 core: owns the program counter, issues single-outstanding requests to instruction memory over a valid/ready interface, and delivers fetched instructions into the IF/ID pipeline register. The decode side, including the immediate generator, consumes id_instr/id_pc. Branch/jump resolution redirects the PC, for example with pc + immediate. The block handles decode stalls with a one-entry skid buffer and discards responses made stale by a redirect.

## Interface
- RESET_PC, 64'h0000_0000_0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  64  fetch address (= pc)
- imem_rsp_valid  in  1  response data valid (exactly one per accepted request, ≥1 cycle after acceptance)
- imem_rsp_data  in  32  fetched instruction
- redirect_valid  in  1  control-flow redirect, single-cycle pulse
- redirect_pc  in  64  new fetch address
- stall  in  1  decode cannot accept; hold IF/ID contents
- id_valid  out  1  IF/ID register holds a valid instruction
- id_instr  out  32  instruction word
- id_pc  out  64  address of id_instr

## Operation
- FSM states: IDLE, REQ, WAIT, DROP, HOLD. The reset state is IDLE. IDLE goes to REQ unconditionally.
- imem_req_valid = (state == REQ). imem_req_addr = pc.
- REQ:
  - On handshake (valid & ready) go to WAIT.
  - redirect_valid: pc <= redirect_pc. If a handshake occurs in the same cycle, go to DROP; otherwise stay in REQ.
- WAIT:
  - rsp_valid with no redirect: capture {rsp_data, pc}. Then pc <= pc + 4, modulo 2^64.
    - If the IF/ID register can accept (!id_valid | !stall), write IF/ID and go to REQ.
    - Otherwise write the skid buffer and go to HOLD.
  - rsp_valid with redirect: discard the response, pc <= redirect_pc, go to REQ.
  - Redirect with no rsp_valid: pc <= redirect_pc, go to DROP.
- DROP:
  - Wait for rsp_valid, discard it, then go to REQ.
  - A redirect while in DROP updates pc and the state stays DROP.
- HOLD:
  - No requests are issued.
  - When !stall, move skid contents into IF/ID, clear the skid, and go to REQ.
  - A redirect clears the skid, sets pc <= redirect_pc, and goes to REQ.
- IF/ID register rules:
  - redirect_valid forces id_valid <= 0 the next cycle. This flush overrides stall and any same-cycle capture.
  - stall & id_valid: all IF/ID fields hold.
  - !stall with no new instruction: id_valid <= 0, and id_instr/id_pc keep their last values.
- redirect_pc[1:0] is not checked; it is issued as given.

## Timing
- Reset values:
  - imem_req_valid 0.
  - imem_req_addr RESET_PC.
  - id_valid 0.
  - id_instr 32'h0000_0013 (NOP).
  - id_pc 0.
  - Skid buffer empty.
- First request is issued 1 cycle after rst_n deassertion (the IDLE cycle).
- Response to IF/ID: id_valid rises on the edge that samples imem_rsp_valid, so it is visible 1 cycle later.
- Throughput is at most 1 instruction per 2 cycles, because only one request is outstanding.
- Redirect to new request: with no outstanding response, imem_req_valid is high with redirect_pc in the cycle after the redirect.
- Reset asserted mid-transaction: all state clears immediately. Any in-flight memory response after reset is the memory's responsibility; the block ignores rsp_valid in IDLE and REQ.

## Configuration
- FETCH_PERF_EN defined:
  - Adds outputs perf_fetch_cnt (out, 32) and perf_drop_cnt (out, 32), both reset to 0 and wrapping at 2^32.
  - perf_fetch_cnt increments on each response delivered to IF/ID or the skid buffer.
  - perf_drop_cnt increments on each discarded response.
- FETCH_PERF_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package fetch_pkg holds:
  - The fetch_state_e enum (IDLE, REQ, WAIT, DROP, HOLD).
  - The NOP_INSTR constant 32'h0000_0013.
  - The PC_W = 64 constant.
  - The fetch_pkt_t struct {instr[31:0], pc[63:0]}.
- Sub-module fetch_skid_buf: a one-entry fetch_pkt_t holding register with load, unload, clear, full, same clk/rst_n.

## Test plan
- Reset release with RESET_PC = 64'h1000 and ready held high; memory returns a response 1 cycle after each accepted request -> requests at 0x1000, 0x1004, 0x1008; id_pc follows 0x1000, 0x1004, 0x1008, id_valid high every other cycle.
- Redirect to 0x2000 during WAIT, then the response arrives -> the response is dropped (id_valid stays 0); the next request address is 0x2000; perf_drop_cnt = 1 with FETCH_PERF_EN.
- Redirect in the same cycle as rsp_valid -> no IF/ID write; request at redirect_pc the next cycle, with no DROP state entered.
- stall held 5 cycles while id_valid = 1 and a response arrives -> the FSM enters HOLD and no requests are issued; on stall release IF/ID takes the skid instruction (pc + 4), then requests resume.
- imem_req_ready low for 3 cycles -> imem_req_valid and addr are held stable until the handshake.
- rst_n asserted while in WAIT -> outputs return to reset values within the same cycle; a late rsp_valid after release is ignored.
